// File: rtl/attack_bar_pkg.sv
// Shared types and constants for the attack bar sprite: FSM states, default colours,
// offset/distance widths and the distance helper.
package attack_bar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int          OFF_W            = 11;
    localparam int          DIST_W           = 11;
    localparam logic [11:0] DEF_BAR_COLOR    = 12'hFFF;
    localparam logic [11:0] DEF_CURSOR_COLOR = 12'h000;

    function automatic logic [11:0] abs_diff12(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/attack_bar_sweep_if.sv
// Video-position, control and result signals of the attack bar sprite.
// master drives positions and controls; slave is the sprite itself.
interface attack_bar_sweep_if;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        new_frame_in;
    logic        start_in;
    logic        press_in;
    logic [11:0] pixel_out;
    logic        in_sprite_out;
    logic        busy_out;
    logic        done_out;
    logic        miss_out;
    logic [10:0] dist_out;

    modport master (
        output x_in, y_in, hcount_in, vcount_in, new_frame_in, start_in, press_in,
        input  pixel_out, in_sprite_out, busy_out, done_out, miss_out, dist_out
    );

    modport slave (
        input  x_in, y_in, hcount_in, vcount_in, new_frame_in, start_in, press_in,
        output pixel_out, in_sprite_out, busy_out, done_out, miss_out, dist_out
    );
endinterface

// File: rtl/attack_bar_sweep_rect_hit.sv
// Combinational point-in-rectangle test over [x, x+W) x [y, y+H).
// One guard bit on each axis keeps the far edge from wrapping.
module rect_hit #(
    parameter int W = 256,
    parameter int H = 64
) (
    input  logic [11:0] i_x,
    input  logic [10:0] i_y,
    input  logic [11:0] i_h,
    input  logic [10:0] i_v,
    output logic        o_hit
);
    logic [12:0] w_x_end;
    logic [11:0] w_y_end;

    assign w_x_end = {1'b0, i_x} + 13'(W);
    assign w_y_end = {1'b0, i_y} + 12'(H);

    assign o_hit = (i_h >= i_x) && ({1'b0, i_h} < w_x_end)
                && (i_v >= i_y) && ({1'b0, i_v} < w_y_end);
endmodule

// File: rtl/attack_bar_sweep.sv
// Attack bar sprite: a cursor sweeps across the bar once per frame until pressed or missed.
// Optional: define ATTACK_BAR_BLINK_EN to blink the frozen cursor every 4 frames in HOLD.
//
// state | meaning
// IDLE  | bar drawn, cursor hidden, waiting for start
// SWEEP | cursor advances STEP pixels per frame, press or edge ends the sweep
// HOLD  | result latched, cursor frozen for HOLD_FRAMES frames
module attack_bar_sweep
    import attack_bar_pkg::*;
#(
    parameter int          WIDTH        = 256,
    parameter int          HEIGHT       = 64,
    parameter int          CURSOR_W     = 8,
    parameter int          STEP         = 4,
    parameter int          HOLD_FRAMES  = 30,
    parameter logic [11:0] BAR_COLOR    = DEF_BAR_COLOR,
    parameter logic [11:0] CURSOR_COLOR = DEF_CURSOR_COLOR
) (
    input  logic clk_in,
    input  logic rst_in,
    attack_bar_sweep_if.slave bus
);
    localparam int               HC_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [OFF_W-1:0] MAX_OFF = OFF_W'(WIDTH - CURSOR_W);
    localparam logic [HC_W-1:0]  HC_LOAD = HC_W'(HOLD_FRAMES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OFF_W-1:0]    r_off;
    logic [HC_W-1:0]     r_hold_cnt;
    logic [11:0]         r_pixel;
    logic                r_in_sprite;
    logic                r_done;
    logic                r_miss;
    logic [DIST_W-1:0]   r_dist;

    logic                w_bar_hit;
    logic                w_cur_hit;
    logic                w_enter_hold;
    logic                w_cursor_vis;
    logic [OFF_W-1:0]    w_off_adv;
    logic [DIST_W-1:0]   w_dist_hit;
    logic [11:0]         w_pixel_nxt;
    logic [11:0]         w_cur_x;

    assign w_cur_x = {1'b0, bus.x_in} + {1'b0, r_off};

    rect_hit #(.W(WIDTH), .H(HEIGHT)) u_bar_hit (
        .i_x   ({1'b0, bus.x_in}),
        .i_y   ({1'b0, bus.y_in}),
        .i_h   ({1'b0, bus.hcount_in}),
        .i_v   ({1'b0, bus.vcount_in}),
        .o_hit (w_bar_hit)
    );

    rect_hit #(.W(CURSOR_W), .H(HEIGHT)) u_cur_hit (
        .i_x   (w_cur_x),
        .i_y   ({1'b0, bus.y_in}),
        .i_h   ({1'b0, bus.hcount_in}),
        .i_v   ({1'b0, bus.vcount_in}),
        .o_hit (w_cur_hit)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start_in) w_state_nxt = ST_SWEEP;
            ST_SWEEP: begin
                if (bus.press_in)                                 w_state_nxt = ST_HOLD;
                else if (bus.new_frame_in && (r_off == MAX_OFF))  w_state_nxt = ST_HOLD;
            end
            ST_HOLD:  if (bus.new_frame_in && (r_hold_cnt == '0)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enter_hold = (r_state == ST_SWEEP) && (w_state_nxt == ST_HOLD);
        w_off_adv    = (r_off > MAX_OFF - OFF_W'(STEP)) ? MAX_OFF : r_off + OFF_W'(STEP);
        w_dist_hit   = DIST_W'(abs_diff12({1'b0, r_off} + 12'(CURSOR_W / 2), 12'(WIDTH / 2)));
        w_cursor_vis = (r_state != ST_IDLE);
`ifdef ATTACK_BAR_BLINK_EN
        // Elapsed HOLD frames; cursor shown for frames 0-3, hidden 4-7, and so on.
        if ((r_state == ST_HOLD) && ((32'(HC_LOAD) - 32'(r_hold_cnt)) & 32'd4) != 32'd0)
            w_cursor_vis = 1'b0;
`endif
        if (w_cur_hit && w_cursor_vis) w_pixel_nxt = CURSOR_COLOR;
        else if (w_bar_hit)            w_pixel_nxt = BAR_COLOR;
        else                           w_pixel_nxt = 12'h000;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_off       <= '0;
            r_hold_cnt  <= '0;
            r_pixel     <= '0;
            r_in_sprite <= 1'b0;
            r_done      <= 1'b0;
            r_miss      <= 1'b0;
            r_dist      <= '0;
        end else begin
            r_pixel     <= w_pixel_nxt;
            r_in_sprite <= w_bar_hit;
            r_done      <= w_enter_hold;
            case (r_state)
                ST_IDLE: if (bus.start_in) begin
                    r_off  <= '0;
                    r_miss <= 1'b0;
                    r_dist <= '0;
                end
                ST_SWEEP: begin
                    // A press freezes the cursor where it was seen, even on a frame pulse.
                    if (bus.press_in) begin
                        r_dist <= w_dist_hit;
                        r_miss <= 1'b0;
                    end else if (bus.new_frame_in) begin
                        if (r_off == MAX_OFF) begin
                            r_miss <= 1'b1;
                            r_dist <= '0;
                        end else begin
                            r_off <= w_off_adv;
                        end
                    end
                    if (w_enter_hold) r_hold_cnt <= HC_LOAD;
                end
                ST_HOLD: if (bus.new_frame_in && (r_hold_cnt != '0)) r_hold_cnt <= r_hold_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.pixel_out     = r_pixel;
    assign bus.in_sprite_out = r_in_sprite;
    assign bus.busy_out      = (r_state != ST_IDLE);
    assign bus.done_out      = r_done;
    assign bus.miss_out      = r_miss;
    assign bus.dist_out      = r_dist;
endmodule

// File: tb/tb_attack_bar_sweep.sv
// Directed bench for attack_bar_sweep: pixel-path vector table plus sweep/hold sequences.
module tb_attack_bar_sweep;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    attack_bar_sweep_if bus();

    attack_bar_sweep dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [10:0] x;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic [11:0] pix;
        logic        ins;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.new_frame_in = 1'b1;
            tick();
            bus.new_frame_in = 1'b0;
        end
    endtask

    task automatic pulse_start();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
    endtask

    // Point at column hc (row inside the bar) and check the registered pixel.
    task automatic probe(input string name, input logic [10:0] hc, input logic [11:0] exp);
        bus.hcount_in = hc;
        bus.vcount_in = 10'd60;
        tick();
        chk(name, 32'(bus.pixel_out), 32'(exp));
    endtask

    initial begin
        tbl[0] = '{x: 11'd100,  hc: 11'd110,  vc: 10'd60,  pix: 12'hFFF, ins: 1'b1};
        tbl[1] = '{x: 11'd100,  hc: 11'd99,   vc: 10'd60,  pix: 12'h000, ins: 1'b0};
        tbl[2] = '{x: 11'd100,  hc: 11'd100,  vc: 10'd50,  pix: 12'hFFF, ins: 1'b1};
        tbl[3] = '{x: 11'd100,  hc: 11'd355,  vc: 10'd60,  pix: 12'hFFF, ins: 1'b1};
        tbl[4] = '{x: 11'd100,  hc: 11'd356,  vc: 10'd60,  pix: 12'h000, ins: 1'b0};
        tbl[5] = '{x: 11'd100,  hc: 11'd200,  vc: 10'd49,  pix: 12'h000, ins: 1'b0};
        tbl[6] = '{x: 11'd100,  hc: 11'd200,  vc: 10'd113, pix: 12'hFFF, ins: 1'b1};
        tbl[7] = '{x: 11'd100,  hc: 11'd200,  vc: 10'd114, pix: 12'h000, ins: 1'b0};
        tbl[8] = '{x: 11'd1900, hc: 11'd2047, vc: 10'd60,  pix: 12'hFFF, ins: 1'b1};
        tbl[9] = '{x: 11'd1900, hc: 11'd5,    vc: 10'd60,  pix: 12'h000, ins: 1'b0};

        bus.x_in = 11'd100;
        bus.y_in = 10'd50;
        bus.hcount_in = 11'd0;
        bus.vcount_in = 10'd0;
        bus.new_frame_in = 1'b0;
        bus.start_in = 1'b0;
        bus.press_in = 1'b0;

        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy_out), 0);
        chk("rst_pixel", 32'(bus.pixel_out), 0);
        chk("rst_dist", 32'(bus.dist_out), 0);
        rst_in = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            bus.x_in = tbl[i].x;
            bus.hcount_in = tbl[i].hc;
            bus.vcount_in = tbl[i].vc;
            tick();
            chk($sformatf("tbl%0d_pixel", i), 32'(bus.pixel_out), 32'(tbl[i].pix));
            chk($sformatf("tbl%0d_in_sprite", i), 32'(bus.in_sprite_out), 32'(tbl[i].ins));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy_out), 0);
        end
        bus.x_in = 11'd100;

        // Press at bar centre after 31 frames.
        pulse_start();
        chk("s1_busy", 32'(bus.busy_out), 1);
        probe("s1_cur_off0", 11'd100, 12'h000);
        probe("s1_bar_off0", 11'd108, 12'hFFF);
        frames(31);
        probe("s1_cur_124", 11'd224, 12'h000);
        probe("s1_cur_124_end", 11'd231, 12'h000);
        probe("s1_bar_after", 11'd232, 12'hFFF);
        probe("s1_bar_before", 11'd223, 12'hFFF);
        chk("s1_done_pre", 32'(bus.done_out), 0);
        bus.press_in = 1'b1;
        tick();
        bus.press_in = 1'b0;
        chk("s1_done", 32'(bus.done_out), 1);
        chk("s1_dist", 32'(bus.dist_out), 0);
        chk("s1_miss", 32'(bus.miss_out), 0);
        tick();
        chk("s1_done_once", 32'(bus.done_out), 0);
        frames(5);
        probe("s1_hold_cur", 11'd224, 12'h000);
        frames(24);
        chk("s1_busy_29", 32'(bus.busy_out), 1);
        frames(1);
        chk("s1_busy_30", 32'(bus.busy_out), 0);
        probe("s1_idle_nocur", 11'd224, 12'hFFF);

        // Press coincident with the 11th frame uses off=40.
        pulse_start();
        frames(10);
        bus.press_in = 1'b1;
        bus.new_frame_in = 1'b1;
        tick();
        bus.press_in = 1'b0;
        bus.new_frame_in = 1'b0;
        chk("s2_done", 32'(bus.done_out), 1);
        chk("s2_dist", 32'(bus.dist_out), 84);
        chk("s2_miss", 32'(bus.miss_out), 0);
        frames(30);
        chk("s2_busy", 32'(bus.busy_out), 0);
        chk("s2_dist_hold", 32'(bus.dist_out), 84);

        // No press: saturate at 248, then miss.
        pulse_start();
        chk("s3_dist_clr", 32'(bus.dist_out), 0);
        frames(62);
        probe("s3_cur_248", 11'd348, 12'h000);
        probe("s3_cur_edge", 11'd355, 12'h000);
        probe("s3_bar_pre", 11'd347, 12'hFFF);
        chk("s3_busy", 32'(bus.busy_out), 1);
        chk("s3_miss_pre", 32'(bus.miss_out), 0);
        frames(1);
        chk("s3_done", 32'(bus.done_out), 1);
        chk("s3_miss", 32'(bus.miss_out), 1);
        chk("s3_dist", 32'(bus.dist_out), 0);
        tick();
        chk("s3_done_once", 32'(bus.done_out), 0);
        frames(29);
        chk("s3_busy_29", 32'(bus.busy_out), 1);
        frames(1);
        chk("s3_busy_30", 32'(bus.busy_out), 0);
        chk("s3_miss_hold", 32'(bus.miss_out), 1);

        // Press and edge-miss together: press wins, dist from off=248.
        pulse_start();
        chk("s4_miss_clr", 32'(bus.miss_out), 0);
        frames(62);
        bus.press_in = 1'b1;
        bus.new_frame_in = 1'b1;
        tick();
        bus.press_in = 1'b0;
        bus.new_frame_in = 1'b0;
        chk("s4_done", 32'(bus.done_out), 1);
        chk("s4_miss", 32'(bus.miss_out), 0);
        chk("s4_dist", 32'(bus.dist_out), 124);
        frames(30);
        chk("s4_busy", 32'(bus.busy_out), 0);

        // Ignored controls: press in IDLE, start in SWEEP.
        bus.press_in = 1'b1;
        tick();
        bus.press_in = 1'b0;
        chk("s5_idle_press_busy", 32'(bus.busy_out), 0);
        chk("s5_idle_press_done", 32'(bus.done_out), 0);
        pulse_start();
        frames(5);
        pulse_start();
        chk("s5_busy", 32'(bus.busy_out), 1);
        probe("s5_cur_kept", 11'd120, 12'h000);
        probe("s5_not_reset", 11'd100, 12'hFFF);

        // Asynchronous reset mid-sweep at off=100.
        frames(20);
        probe("s6_cur_100", 11'd200, 12'h000);
        #3 rst_in = 1'b0;
        #1;
        chk("s6_busy", 32'(bus.busy_out), 0);
        chk("s6_pixel", 32'(bus.pixel_out), 0);
        chk("s6_in_sprite", 32'(bus.in_sprite_out), 0);
        chk("s6_done", 32'(bus.done_out), 0);
        chk("s6_miss", 32'(bus.miss_out), 0);
        chk("s6_dist", 32'(bus.dist_out), 0);
        tick();
        rst_in = 1'b1;
        tick();
        chk("s6_done_after", 32'(bus.done_out), 0);
        chk("s6_busy_after", 32'(bus.busy_out), 0);
        probe("s6_idle_bar", 11'd200, 12'hFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/attack_bar_sweep.md
Name: attack_bar_sweep

Overview:
- Animated attack bar for the battle screen: a fixed rectangle with a vertical cursor that sweeps left to right, advancing once per video frame.
- Player press freezes the cursor and reports distance from bar centre; no press before the right edge reports a miss.
- Sits in the sprite layer of the video pipeline; output is registered and feeds the pixel mux alongside the other sprites.

Parameters:
- WIDTH, 256, bar width in pixels
- HEIGHT, 64, bar height in pixels
- CURSOR_W, 8, cursor width in pixels (CURSOR_W < WIDTH)
- STEP, 4, cursor advance in pixels per frame
- HOLD_FRAMES, 30, frames the frozen cursor stays visible after the result
- BAR_COLOR, 12'hFFF, bar fill colour
- CURSOR_COLOR, 12'h000, cursor colour

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-low reset
- x_in  input  11  bar left edge
- y_in  input  10  bar top edge
- hcount_in  input  11  current pixel column
- vcount_in  input  10  current pixel row
- new_frame_in  input  1  one-cycle pulse at frame start
- start_in  input  1  begin a sweep (pulse)
- press_in  input  1  player hit (pulse)
- pixel_out  output  12  registered pixel colour, 0 outside sprite
- in_sprite_out  output  1  registered in-rectangle flag
- busy_out  output  1  high in SWEEP or HOLD
- done_out  output  1  one-cycle pulse when a result is latched
- miss_out  output  1  latched result: 1 = no press before edge
- dist_out  output  11  latched |cursor centre - bar centre|

Behaviour:
- Reset (rst_in low, async): state IDLE, cursor offset 0, all outputs 0.
- Cursor offset off is 11 bits, range 0..MAX_OFF = WIDTH-CURSOR_W. Cursor covers columns x_in+off .. x_in+off+CURSOR_W-1.
- FSM:
  - IDLE: cursor is hidden and the bar is drawn. start_in sets off=0 and moves to SWEEP.
  - SWEEP: on new_frame_in, off = min(off+STEP, MAX_OFF). If press_in is high, latch the result and go to HOLD. If new_frame_in arrives with off already at MAX_OFF, set miss_out=1, dist_out=0 and go to HOLD.
  - HOLD: cursor frozen. A frame counter counts new_frame_in pulses; after HOLD_FRAMES pulses, return to IDLE.
- Result on press:
  - dist_out = |(off + CURSOR_W/2) - WIDTH/2|, using the pre-update off if new_frame_in coincides.
  - miss_out = 0.
  - done_out pulses the cycle after the transition into HOLD, for both hit and miss.
- miss_out and dist_out hold their values until the next start_in.
- Simultaneous events:
  - press_in and the edge-miss condition in the same cycle: press wins.
  - start_in is ignored outside IDLE.
  - press_in is ignored outside SWEEP.
- Pixel path, 1-cycle latency:
  - in_sprite_out registers the rectangle test [x_in, x_in+WIDTH) x [y_in, y_in+HEIGHT).
  - pixel_out = CURSOR_COLOR if in the cursor columns and state is not IDLE; else BAR_COLOR if in the rectangle; else 0.
  - Compare in 12-bit arithmetic so x_in+WIDTH does not wrap.
- Reset asserted mid-sweep returns to IDLE immediately. No done_out pulse is produced.

Optional Feature:
- ATTACK_BAR_BLINK_EN defined: in HOLD the cursor toggles visibility every 4 frames, visible first. Blink applies to the cursor only; the bar stays lit.
- Undefined: the cursor is solid throughout HOLD.

Decomposition:
- Package attack_bar_pkg: state enum (IDLE, SWEEP, HOLD), default colour constants, offset/distance widths.
- One sub-module, rect_hit: a combinational point-in-rectangle test with parameterised width and height. It is instantiated twice, once for the bar and once for the cursor.

Test Plan:
- Reset then idle: hcount=x_in+10, vcount=y_in+10 -> next cycle pixel_out=12'hFFF, in_sprite_out=1, busy_out=0; outside the rectangle -> pixel_out=0.
- Start, then 31 new_frame pulses, then press -> off=124, dist_out=|128-128|=0, miss_out=0, done_out pulses once.
- Start, 10 frames, press coincident with the 11th new_frame -> dist_out computed from off=40: |44-128|=84.
- Start with no press -> off saturates at 248 after 62 frames; the next new_frame gives miss_out=1, dist_out=0, done_out pulse; busy_out drops after 30 further frames.
- start_in during SWEEP and press_in during IDLE -> no state change, off unchanged.
- rst_in low mid-sweep (off=100) -> immediate IDLE, all outputs 0, no done_out pulse.
